// File: rtl/leer_status_pkg.sv
// leer_status_pkg: control codes, status bit positions and FSM encoding shared by the status reader and writer
package leer_status_pkg;
  localparam logic [1:0] LEER_CODE = 2'd2;
  localparam logic [1:0] ESCR_CODE = 2'd3;
  localparam int FH_POS = 4;
  localparam int CRONO_POS = 3;
  typedef enum logic [2:0] {ESPERA, FASE0, MUESTRA1, MUESTRA2, ACTUALIZA, FALLO, HECHO} state_t;
  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction
endpackage

// File: rtl/leer_status.sv
// leer_status: double-reads the RTC status byte on the bus tick grid and publishes the decoded flags
module leer_status
  import leer_status_pkg::*;
#(
  parameter logic [1:0] CTRL_LEER = LEER_CODE,
  parameter int BIT_FH = FH_POS,
  parameter int BIT_CRONO = CRONO_POS,
  parameter int MAX_REINT = 3
) (
  input  logic       reloj,
  input  logic       resetM,
  input  logic [1:0] Control,
  input  logic       enable_cont_16,
  input  logic       enable_cont_MS,
  input  logic [7:0] Dato_leido,
  output logic       en_lectura_bus,
  output logic       F_H_leido,
  output logic       crono_leido,
  output logic [7:0] status_raw,
  output logic       status_valido,
  output logic       error_status
);
  state_t state, nxt;
  logic [2:0] reint, reint_inc;
  logic [7:0] m1;
  logic tick, leer, miss;
  assign tick = enable_cont_16 & enable_cont_MS;
  assign leer = Control == CTRL_LEER;
  assign miss = state == MUESTRA2 && leer && tick && Dato_leido != m1;
  assign reint_inc = sat_inc(reint);
  always_comb begin
    nxt = state;
    case (state)
      ESPERA:    nxt = leer ? FASE0 : ESPERA;
      FASE0:     nxt = !leer ? ESPERA : tick ? MUESTRA1 : FASE0;
      MUESTRA1:  nxt = !leer ? ESPERA : tick ? MUESTRA2 : MUESTRA1;
      MUESTRA2:  nxt = !leer ? ESPERA : !tick ? MUESTRA2 : !miss ? ACTUALIZA :
                       reint_inc == 3'(MAX_REINT) ? FALLO : FASE0;
      ACTUALIZA: nxt = HECHO;
      FALLO:     nxt = HECHO;
      HECHO:     nxt = leer ? HECHO : ESPERA;
      default:   nxt = ESPERA;
    endcase
  end
  // outputs decode the next state so they line up with the state they describe
  always_ff @(posedge reloj) begin
    if (resetM) begin
      state <= ESPERA;
      reint <= 3'd0;
      m1 <= 8'd0;
      en_lectura_bus <= 1'b0;
      F_H_leido <= 1'b0;
      crono_leido <= 1'b0;
      status_raw <= 8'd0;
      status_valido <= 1'b0;
      error_status <= 1'b0;
    end else begin
      state <= nxt;
      en_lectura_bus <= nxt inside {FASE0, MUESTRA1, MUESTRA2};
      status_valido <= nxt == ACTUALIZA;
      error_status <= nxt == FALLO;
      reint <= nxt == ESPERA ? 3'd0 : miss ? reint_inc : reint;
      if (state == MUESTRA1 && nxt == MUESTRA2) m1 <= Dato_leido;
      if (nxt == ACTUALIZA) begin
        status_raw <= m1;
        F_H_leido <= m1[BIT_FH];
        crono_leido <= m1[BIT_CRONO];
      end
    end
  end
endmodule

// File: tb/tb_leer_status.sv
// tb_leer_status: directed table, hand sequences and random traffic against a transaction-level reference
module tb_leer_status;
  logic reloj = 1'b0, resetM = 1'b1;
  logic [1:0] Control = 2'd2;
  logic enable_cont_16 = 1'b0, enable_cont_MS = 1'b0;
  logic [7:0] Dato_leido = 8'd0;
  logic en_lectura_bus, F_H_leido, crono_leido, status_valido, error_status;
  logic [7:0] status_raw;
  int tests = 0, fails = 0;
  int saw_v = 0, saw_e = 0, saw_en = 0;
  bit ready = 0;

  leer_status dut (
    .reloj(reloj), .resetM(resetM), .Control(Control),
    .enable_cont_16(enable_cont_16), .enable_cont_MS(enable_cont_MS),
    .Dato_leido(Dato_leido), .en_lectura_bus(en_lectura_bus),
    .F_H_leido(F_H_leido), .crono_leido(crono_leido), .status_raw(status_raw),
    .status_valido(status_valido), .error_status(error_status)
  );

  always #5 reloj = ~reloj;

  // reference: a read is active from request until a consistent pair or the third failed attempt
  bit m_act, m_post, m_held, m_v, m_e;
  int m_k, m_fail;
  logic [7:0] m_s1, m_raw;
  always @(posedge reloj) begin
    m_v = 0;
    m_e = 0;
    if (resetM) begin
      m_act = 0; m_post = 0; m_held = 0; m_k = 0; m_fail = 0; m_raw = 0;
    end else if (m_post) begin
      m_post = 0; m_held = 1;
    end else if (m_held) begin
      if (Control != 2'd2) begin m_held = 0; m_fail = 0; end
    end else if (!m_act) begin
      if (Control == 2'd2) begin m_act = 1; m_k = 0; end
    end else if (Control != 2'd2) begin
      m_act = 0; m_fail = 0;
    end else if (enable_cont_16 && enable_cont_MS) begin
      if (m_k < 2) begin
        if (m_k == 1) m_s1 = Dato_leido;
        m_k++;
      end else if (Dato_leido == m_s1) begin
        m_raw = m_s1; m_v = 1; m_act = 0; m_post = 1;
      end else begin
        m_fail++;
        m_k = 0;
        if (m_fail == 3) begin m_e = 1; m_act = 0; m_post = 1; end
      end
    end
    ready = 1;
  end

  always @(negedge reloj) if (ready) begin
    logic [12:0] act, exp;
    act = {en_lectura_bus, F_H_leido, crono_leido, status_raw, status_valido, error_status};
    exp = {m_act, m_raw[4], m_raw[3], m_raw, m_v, m_e};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL cycle_model t=%0t got %h want %h", $time, act, exp);
    end
    saw_v += int'(status_valido);
    saw_e += int'(error_status);
    saw_en += int'(en_lectura_bus);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic step(input bit t, input logic [7:0] d);
    enable_cont_16 = t ? 1'b1 : 1'($urandom_range(0, 1));
    enable_cont_MS = t ? 1'b1 : ~enable_cont_16;
    Dato_leido = d;
    @(posedge reloj);
    #1;
  endtask

  task automatic period(input logic [7:0] d);
    repeat (3) step(0, 8'($urandom));
    step(1, d);
  endtask

  typedef struct {
    logic [5:0][7:0] seq;
    int n_v, n_e, n_en;
    logic [7:0] raw;
    logic fh, cr;
  } rec_t;
  rec_t tbl[$];

  function automatic rec_t mk(input logic [47:0] s, input int v, input int e, input int en,
                              input logic [7:0] raw, input logic fh, input logic cr);
    rec_t r;
    r.seq = s; r.n_v = v; r.n_e = e; r.n_en = en; r.raw = raw; r.fh = fh; r.cr = cr;
    return r;
  endfunction

  task automatic do_read(input rec_t r, input int idx);
    int v0, e0, en0;
    v0 = saw_v; e0 = saw_e; en0 = saw_en;
    Control = 2'd2;
    step(0, 8'd0);
    for (int t = 0; t < 9 && saw_v == v0 && saw_e == e0; t++)
      period(t % 3 == 1 ? r.seq[2 * (t / 3)] : t % 3 == 2 ? r.seq[2 * (t / 3) + 1] : 8'($urandom));
    repeat (2) step(0, 8'd0);
    chk($sformatf("tbl%0d_valid", idx), saw_v - v0, r.n_v);
    chk($sformatf("tbl%0d_error", idx), saw_e - e0, r.n_e);
    chk($sformatf("tbl%0d_raw", idx), status_raw, r.raw);
    chk($sformatf("tbl%0d_fh", idx), F_H_leido, r.fh);
    chk($sformatf("tbl%0d_crono", idx), crono_leido, r.cr);
    if (r.n_en != 0) chk($sformatf("tbl%0d_en_cycles", idx), saw_en - en0, r.n_en);
    Control = 2'd0;
    repeat (3) step(0, 8'd0);
  endtask

  initial begin
    int v0, e0;
    // seq packs {b2,a2,b1,a1,b0,a0}: attempt k samples a_k then b_k
    tbl.push_back(mk({32'h0, 8'h18, 8'h18}, 1, 0, 12, 8'h18, 1, 1));
    tbl.push_back(mk({16'h0, 8'h08, 8'h08, 8'h08, 8'h10}, 1, 0, 0, 8'h08, 0, 1));
    tbl.push_back(mk({8'h02, 8'h01, 8'h55, 8'hAA, 8'hAA, 8'h55}, 0, 1, 0, 8'h08, 0, 1));
    tbl.push_back(mk({32'h0, 8'hF7, 8'hF7}, 1, 0, 12, 8'hF7, 1, 0));
    tbl.push_back(mk({32'h0, 8'h00, 8'h00}, 1, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk({16'h0, 8'h3C, 8'h3C, 8'hC3, 8'h3C}, 1, 0, 0, 8'h3C, 1, 1));
    repeat (6) step(1, 8'hFF);
    chk("reset_outputs", {en_lectura_bus, F_H_leido, crono_leido, status_raw, status_valido, error_status}, 0);
    chk("reset_no_pulse", saw_v + saw_e, 0);
    Control = 2'd0;
    resetM = 1'b0;
    repeat (2) step(0, 8'd0);
    foreach (tbl[i]) do_read(tbl[i], i);
    v0 = saw_v; e0 = saw_e;
    Control = 2'd2;
    step(0, 8'd0);
    period(8'h77);
    period(8'h77);
    Control = 2'd0;
    step(0, 8'd0);
    chk("abort_en", en_lectura_bus, 0);
    repeat (4) step(1, 8'h77);
    chk("abort_no_pulse", saw_v - v0 + saw_e - e0, 0);
    chk("abort_raw_held", status_raw, 8'h3C);
    Control = 2'd2;
    step(0, 8'd0);
    repeat (4) period(8'h5A);
    chk("fresh_raw", status_raw, 8'h5A);
    chk("fresh_valid", saw_v - v0, 1);
    Control = 2'd0;
    repeat (3) step(0, 8'd0);
    v0 = saw_v;
    Control = 2'd2;
    step(0, 8'd0);
    repeat (8) period(8'h24);
    chk("held_single_read", saw_v - v0, 1);
    chk("held_en_low", en_lectura_bus, 0);
    Control = 2'd0;
    repeat (2) step(0, 8'd0);
    Control = 2'd2;
    step(0, 8'd0);
    repeat (4) period(8'h99);
    chk("retrigger_valid", saw_v - v0, 2);
    chk("retrigger_raw", status_raw, 8'h99);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) Control = 2'($urandom_range(0, 3));
      else if ($urandom_range(0, 9) == 0) Control = 2'd2;
      resetM = $urandom_range(0, 299) == 0;
      step($urandom_range(0, 2) == 0, $urandom_range(0, 1) ? 8'h18 : 8'h08);
    end
    resetM = 1'b0;
    step(0, 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
